// File: rtl/hssi_tc_mailbox_responder.sv
// hssi_tc_mailbox_responder
// AFU-side responder for the HSSI traffic-controller mailbox. The host drives
// CMD/ADDRESS/RDDATA/WRDATA through a 4-word CSR window. Each accepted RD/WR
// command becomes exactly one Avalon-MM access on the traffic generator/monitor
// CSR space. When the access completes, an ack is raised for the host to poll.
// Optional feature macro: HSSI_MB_TIMEOUT_EN. When it is defined, a read that
// gets no response within TIMEOUT_CYCLES completes with RDDATA=0xDEADBEEF and
// CMD.err set.
module hssi_tc_mailbox_responder #(
   parameter int TC_ADDR_W      = 16,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 csr_write,
   input  logic                 csr_read,
   input  logic [1:0]           csr_address,
   input  logic [DATA_W-1:0]    csr_writedata,
   output logic [DATA_W-1:0]    csr_readdata,
   output logic                 csr_readdatavalid,
   output logic [TC_ADDR_W-1:0] tc_address,
   output logic                 tc_read,
   output logic                 tc_write,
   output logic [DATA_W-1:0]    tc_writedata,
   input  logic [DATA_W-1:0]    tc_readdata,
   input  logic                 tc_readdatavalid,
   input  logic                 tc_waitrequest
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t                 state_q;
   logic                   cmdRd_q;
   logic                   cmdWr_q;
   logic                   cmdAck_q;
   logic                   busy_q;
   logic [DATA_W-1:0]      address_q;
   logic [DATA_W-1:0]      wrData_q;
   logic [DATA_W-1:0]      rdData_q;
   logic [TC_ADDR_W-1:0]   tcAddress_q;
   logic [DATA_W-1:0]      tcWriteData_q;
   logic                   tcRead_q;
   logic                   tcWrite_q;
   logic [DATA_W-1:0]      readData_q;
   logic                   readValid_q;
   logic [DATA_W-1:0]      readMux_d;
   logic [DATA_W-1:0]      cmdWord;
   logic                   errBit;
   logic                   cmdWrite;
   logic                   addrWrite;
   logic                   wrDataWrite;

`ifdef HSSI_MB_TIMEOUT_EN
   localparam int TimeoutCntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TimeoutCntW-1:0] TimeoutLast = TimeoutCntW'(TIMEOUT_CYCLES - 1);
   logic [TimeoutCntW-1:0] timeoutCnt_q;
   logic                   err_q;
   assign errBit = err_q;
`else
   assign errBit = 1'b0;
`endif

   // Host writes to the mailbox only take effect while no access is in flight
   assign cmdWrite    = csr_write && (csr_address == 2'd0) && !busy_q;
   assign addrWrite   = csr_write && (csr_address == 2'd1) && !busy_q;
   assign wrDataWrite = csr_write && (csr_address == 2'd3) && !busy_q;

   assign tc_address        = tcAddress_q;
   assign tc_writedata      = tcWriteData_q;
   assign tc_read           = tcRead_q;
   assign tc_write          = tcWrite_q;
   assign csr_readdata      = readData_q;
   assign csr_readdatavalid = readValid_q;

   // Assemble the CMD status word and select the word the host is reading
   always_comb begin
      cmdWord    = '0;
      cmdWord[0] = cmdRd_q;
      cmdWord[1] = cmdWr_q;
      cmdWord[2] = cmdAck_q;
      cmdWord[3] = busy_q;
      cmdWord[4] = errBit;
      readMux_d  = '0;
      case (csr_address)
         2'd0:    readMux_d = cmdWord;
         2'd1:    readMux_d = address_q;
         2'd2:    readMux_d = rdData_q;
         default: readMux_d = wrData_q;
      endcase
   end

   // Registered host read port, so a read in the ack cycle sees the old CMD
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         readData_q  <= '0;
         readValid_q <= 1'b0;
      end else begin
         readValid_q <= csr_read;
         if (csr_read) begin
            readData_q <= readMux_d;
         end
      end
   end

   // ADDRESS and WRDATA holding registers, frozen while an access is running
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         address_q <= '0;
         wrData_q  <= '0;
      end else begin
         if (addrWrite) begin
            address_q <= csr_writedata;
         end
         if (wrDataWrite) begin
            wrData_q <= csr_writedata;
         end
      end
   end

   // Command decode and the single-access Avalon-MM sequencer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cmdRd_q       <= 1'b0;
         cmdWr_q       <= 1'b0;
         cmdAck_q      <= 1'b0;
         busy_q        <= 1'b0;
         rdData_q      <= '0;
         tcAddress_q   <= '0;
         tcWriteData_q <= '0;
         tcRead_q      <= 1'b0;
         tcWrite_q     <= 1'b0;
`ifdef HSSI_MB_TIMEOUT_EN
         timeoutCnt_q  <= '0;
         err_q         <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (cmdWrite) begin
                  case (csr_writedata[1:0])
                     2'b01, 2'b10: begin
                        cmdRd_q       <= !csr_writedata[1];
                        cmdWr_q       <= csr_writedata[1];
                        cmdAck_q      <= 1'b0;
                        busy_q        <= 1'b1;
                        tcAddress_q   <= address_q[TC_ADDR_W-1:0];
                        tcWriteData_q <= wrData_q;
                        tcRead_q      <= !csr_writedata[1];
                        tcWrite_q     <= csr_writedata[1];
                        state_q       <= csr_writedata[1] ? WR_REQ : RD_REQ;
`ifdef HSSI_MB_TIMEOUT_EN
                        err_q         <= 1'b0;
`endif
                     end
                     2'b00: begin
                        cmdRd_q  <= 1'b0;
                        cmdWr_q  <= 1'b0;
                        cmdAck_q <= 1'b0;
`ifdef HSSI_MB_TIMEOUT_EN
                        err_q    <= 1'b0;
`endif
                     end
                     default: begin
                        cmdAck_q <= 1'b0;
                     end
                  endcase
               end
            end
            RD_REQ: begin
               if (!tc_waitrequest) begin
                  tcRead_q <= 1'b0;
                  if (tc_readdatavalid) begin
                     rdData_q <= tc_readdata;
                     state_q  <= DONE;
                  end else begin
                     state_q  <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (tc_readdatavalid) begin
                  rdData_q <= tc_readdata;
                  state_q  <= DONE;
               end
`ifdef HSSI_MB_TIMEOUT_EN
               else if (timeoutCnt_q == TimeoutLast) begin
                  rdData_q <= DATA_W'(32'hDEADBEEF);
                  err_q    <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  timeoutCnt_q <= timeoutCnt_q + TimeoutCntW'(1);
               end
`endif
            end
            WR_REQ: begin
               if (!tc_waitrequest) begin
                  tcWrite_q <= 1'b0;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               busy_q   <= 1'b0;
               cmdAck_q <= 1'b1;
               state_q  <= IDLE;
`ifdef HSSI_MB_TIMEOUT_EN
               timeoutCnt_q <= '0;
`endif
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hssi_tc_mailbox_responder.sv
// tb_hssi_tc_mailbox_responder
// Directed stimulus for the HSSI mailbox responder. Host readbacks and
// traffic-controller accesses are predicted into queues when the stimulus is
// issued. Two monitors pop and compare them whenever the DUT presents them.
// Build with HSSI_MB_TIMEOUT_EN to also exercise the read timeout.
module tb_hssi_tc_mailbox_responder;

`ifdef HSSI_MB_TIMEOUT_EN
   localparam int TimeoutCycles = 16;
`else
   localparam int TimeoutCycles = 1024;
`endif

   logic        clk;
   logic        rst;
   logic        csr_write;
   logic        csr_read;
   logic [1:0]  csr_address;
   logic [31:0] csr_writedata;
   logic [31:0] csr_readdata;
   logic        csr_readdatavalid;
   logic [15:0] tc_address;
   logic        tc_read;
   logic        tc_write;
   logic [31:0] tc_writedata;
   logic [31:0] tc_readdata;
   logic        tc_readdatavalid;
   logic        tc_waitrequest;

   typedef struct {
      logic        isWrite;
      logic [15:0] addr;
      logic [31:0] data;
      int          hold;
   } tcExp_t;

   logic [31:0] expRead[$];
   tcExp_t      expTc[$];
   int          errors = 0;
   int          checks = 0;
   int          holdCnt = 0;

   hssi_tc_mailbox_responder #(
      .TC_ADDR_W      (16),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (TimeoutCycles)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .csr_write         (csr_write),
      .csr_read          (csr_read),
      .csr_address       (csr_address),
      .csr_writedata     (csr_writedata),
      .csr_readdata      (csr_readdata),
      .csr_readdatavalid (csr_readdatavalid),
      .tc_address        (tc_address),
      .tc_read           (tc_read),
      .tc_write          (tc_write),
      .tc_writedata      (tc_writedata),
      .tc_readdata       (tc_readdata),
      .tc_readdatavalid  (tc_readdatavalid),
      .tc_waitrequest    (tc_waitrequest)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence never completes
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Host readback monitor: every readdatavalid consumes one predicted value
   always @(negedge clk) begin
      if (!rst && csr_readdatavalid) begin
         if (expRead.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_readdatavalid: got data 0x%0h, expected no response", csr_readdata);
         end else begin
            checkOutput("csr_readdata", csr_readdata, expRead.pop_front());
         end
      end
   end

   // Traffic-controller monitor: checks every held request cycle and the hold length
   always @(negedge clk) begin
      if (!rst && (tc_read || tc_write)) begin
         if (expTc.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_tc_access: got rd=%0b wr=%0b addr=0x%0h, expected none",
                     tc_read, tc_write, tc_address);
         end else begin
            holdCnt++;
            checkOutput("tc_address", {16'h0, tc_address}, {16'h0, expTc[0].addr});
            checkOutput("tc_rd_wr", {30'h0, tc_write, tc_read},
                        {30'h0, expTc[0].isWrite, !expTc[0].isWrite});
            if (expTc[0].isWrite) begin
               checkOutput("tc_writedata", tc_writedata, expTc[0].data);
            end
            if (!tc_waitrequest) begin
               checkOutput("tc_hold_cycles", 32'(holdCnt), 32'(expTc[0].hold));
               void'(expTc.pop_front());
               holdCnt = 0;
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hostWrite(input logic [1:0] addr, input logic [31:0] data);
      csr_write     = 1'b1;
      csr_address   = addr;
      csr_writedata = data;
      tick();
      csr_write     = 1'b0;
   endtask

   task automatic hostRead(input logic [1:0] addr, input logic [31:0] expected);
      expRead.push_back(expected);
      csr_read    = 1'b1;
      csr_address = addr;
      tick();
      csr_read    = 1'b0;
   endtask

   task automatic expectTc(input logic isWrite, input logic [15:0] addr, input logic [31:0] data, input int hold);
      tcExp_t e;
      e.isWrite = isWrite;
      e.addr    = addr;
      e.data    = data;
      e.hold    = hold;
      expTc.push_back(e);
   endtask

   task automatic slaveRespond(input logic [31:0] data);
      tc_readdatavalid = 1'b1;
      tc_readdata      = data;
      tick();
      tc_readdatavalid = 1'b0;
      tc_readdata      = '0;
   endtask

   task automatic applyStimulus();
      // Write: WRDATA=0x20, ADDRESS=0x00, CMD=2; ack lands on the third edge
      hostWrite(2'd3, 32'h20);
      hostWrite(2'd1, 32'h0);
      expectTc(1'b1, 16'h0000, 32'h20, 1);
      hostWrite(2'd0, 32'h2);
      tick();
      hostRead(2'd0, 32'hA);
      hostRead(2'd0, 32'h6);

      // Read of TM_PKT_GOOD, response two cycles after the request is accepted
      hostWrite(2'd1, 32'h101);
      expectTc(1'b0, 16'h0101, 32'h20, 1);
      hostWrite(2'd0, 32'h1);
      tick(2);
      slaveRespond(32'h1234);
      tick();
      hostRead(2'd0, 32'h5);
      hostRead(2'd2, 32'h1234);

      // Stray readdatavalid while idle and a write to read-only RDDATA are ignored
      slaveRespond(32'hBAD);
      hostWrite(2'd2, 32'hFFFF);
      hostRead(2'd2, 32'h1234);

      // Response in the same cycle the read request is accepted
      hostWrite(2'd1, 32'h200);
      expectTc(1'b0, 16'h0200, 32'h20, 1);
      hostWrite(2'd0, 32'h1);
      slaveRespond(32'h1);
      tick();
      hostRead(2'd0, 32'h5);
      hostRead(2'd2, 32'h1);

      // Write stalled by waitrequest for 5 cycles: request held for 6
      hostWrite(2'd3, 32'hCAFE0001);
      hostWrite(2'd1, 32'hF4);
      tc_waitrequest = 1'b1;
      expectTc(1'b1, 16'h00F4, 32'hCAFE0001, 6);
      hostWrite(2'd0, 32'h2);
      tick(5);
      tc_waitrequest = 1'b0;
      tick(2);
      hostRead(2'd0, 32'h6);

      // CMD=3 only clears ack; then writes while busy are dropped
      hostWrite(2'd0, 32'h3);
      hostRead(2'd0, 32'h2);
      hostWrite(2'd1, 32'h104);
      tc_waitrequest = 1'b1;
      expectTc(1'b0, 16'h0104, 32'hCAFE0001, 5);
      hostWrite(2'd0, 32'h1);
      hostWrite(2'd0, 32'h2);
      hostWrite(2'd1, 32'h55);
      hostWrite(2'd3, 32'h77);
      hostRead(2'd0, 32'h9);
      tc_waitrequest = 1'b0;
      tick();
      slaveRespond(32'h42);
      tick();
      hostRead(2'd0, 32'h5);
      hostRead(2'd1, 32'h104);
      hostRead(2'd3, 32'hCAFE0001);
      hostRead(2'd2, 32'h42);

      // Reset in the middle of RD_WAIT clears everything at once
      hostWrite(2'd1, 32'h102);
      expectTc(1'b0, 16'h0102, 32'hCAFE0001, 1);
      hostWrite(2'd0, 32'h1);
      tick();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_tc_read", {31'h0, tc_read}, 32'h0);
      checkOutput("rst_tc_write", {31'h0, tc_write}, 32'h0);
      checkOutput("rst_tc_address", {16'h0, tc_address}, 32'h0);
      checkOutput("rst_tc_writedata", tc_writedata, 32'h0);
      checkOutput("rst_csr_readdata", csr_readdata, 32'h0);
      checkOutput("rst_csr_readdatavalid", {31'h0, csr_readdatavalid}, 32'h0);
      tick();
      rst = 1'b0;
      slaveRespond(32'h999);
      hostRead(2'd2, 32'h0);
      hostRead(2'd0, 32'h0);
      hostRead(2'd1, 32'h0);
      hostRead(2'd3, 32'h0);

`ifdef HSSI_MB_TIMEOUT_EN
      // No response: timeout after TimeoutCycles cycles in RD_WAIT
      hostWrite(2'd1, 32'h10C);
      expectTc(1'b0, 16'h010C, 32'h0, 1);
      hostWrite(2'd0, 32'h1);
      tick(15);
      hostRead(2'd0, 32'h9);
      tick(2);
      hostRead(2'd0, 32'h15);
      hostRead(2'd2, 32'hDEADBEEF);
      hostWrite(2'd0, 32'h0);
      hostRead(2'd0, 32'h0);
`endif
   endtask

   // Main sequence: reset checks, directed stimulus, drain and summary
   initial begin
      rst              = 1'b1;
      csr_write        = 1'b0;
      csr_read         = 1'b0;
      csr_address      = 2'd0;
      csr_writedata    = '0;
      tc_readdata      = '0;
      tc_readdatavalid = 1'b0;
      tc_waitrequest   = 1'b0;
      #1;
      checkOutput("reset_tc_read", {31'h0, tc_read}, 32'h0);
      checkOutput("reset_tc_write", {31'h0, tc_write}, 32'h0);
      checkOutput("reset_csr_readdatavalid", {31'h0, csr_readdatavalid}, 32'h0);
      tick(2);
      rst = 1'b0;
      tick();
      hostRead(2'd0, 32'h0);
      hostRead(2'd1, 32'h0);
      hostRead(2'd2, 32'h0);
      hostRead(2'd3, 32'h0);

      applyStimulus();

      tick(4);
      checkOutput("pending_reads", 32'(expRead.size()), 32'h0);
      checkOutput("pending_tc_accesses", 32'(expTc.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
